// File: rtl/controlador_mdio_pkg.sv
// Shared definitions for the host-side MDIO management controller:
// FSM encoding, opcodes, frame layout and a small opcode helper.
package controlador_mdio_pkg;

  // FSM encoding, kept as plain constants for legacy tool compatibility
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITE     = 2'd1;
  localparam logic [1:0] ST_READ_ADDR = 2'd2;
  localparam logic [1:0] ST_READ_DATA = 2'd3;

  // Opcodes carried in the OP field
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  // Frame geometry
  localparam int FRAME_BITS = 32;
  localparam int DATA_BITS  = 16;

  // OP field position inside the frame
  localparam int OP_MSB = 29;
  localparam int OP_LSB = 28;

  // Extract the OP field from a frame
  function automatic logic [1:0] frame_op(input logic [FRAME_BITS-1:0] frame);
    return frame[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/controlador_mdio_mdc_div.sv
// Gated CLK/2 divider producing MDC. While enabled MDC toggles on every
// CLK edge; when disabled it is forced back to 0. The rise/fall strobes
// announce what MDC does at the coming CLK edge so the FSM can drive
// data on falls and sample on falls of the data phase.
module mdio_mdc_div (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic mdc,
  output logic rise,
  output logic fall
);

  assign rise = en & ~mdc;
  assign fall = en & mdc;

  // MDC toggle register, parked low whenever the divider is disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc <= 1'b0;
    end else if (en) begin
      mdc <= ~mdc;
    end else begin
      mdc <= 1'b0;
    end
  end

endmodule

// File: rtl/controlador_mdio.sv
// Host-side MDIO controller: serializes one 32-bit frame MSB first with a
// generated MDC, and for read frames releases the bus after the 16-bit
// address header and captures 16 data bits from the PHY side.
module controlador_mdio
  import controlador_mdio_pkg::*;
(
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  MDIO_START,
  input  logic [FRAME_BITS-1:0] T_DATA,
  input  logic                  MDIO_IN,
  output logic                  MDC,
  output logic                  MDIO_OE,
  output logic                  MDIO_OUT,
  output logic [DATA_BITS-1:0]  RD_DATA,
  output logic                  DATA_RDY
);

  logic [1:0]            state_r;
  logic [5:0]            cnt_r;
  logic [FRAME_BITS-1:0] frame_r;
  // First 15 samples of a read; the 16th goes straight into RD_DATA
  logic [DATA_BITS-2:0]  shadow_r;
  logic                  oe_r;
  logic                  out_r;
  logic [DATA_BITS-1:0]  rd_data_r;
  logic                  rdy_r;
  logic                  mdc_en_s;
  logic                  mdc_rise_s;
  logic                  mdc_fall_s;
  logic [1:0]            op_s;

  assign op_s     = frame_op(T_DATA);
  assign mdc_en_s = (state_r != ST_IDLE);

  mdio_mdc_div u_mdc_div (
    .clk  (CLK),
    .rst  (reset),
    .en   (mdc_en_s),
    .mdc  (MDC),
    .rise (mdc_rise_s),
    .fall (mdc_fall_s)
  );

  // Transaction FSM: frame rotation, bus drive, read sampling and result
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 6'd0;
      frame_r   <= '0;
      shadow_r  <= '0;
      oe_r      <= 1'b0;
      out_r     <= 1'b0;
      rd_data_r <= '0;
      rdy_r     <= 1'b0;
    end else begin
      rdy_r <= 1'b0;
      // cnt_r counts CLK edges since the start was accepted
      if (mdc_rise_s || mdc_fall_s) begin
        cnt_r <= cnt_r + 6'd1;
      end else begin
        cnt_r <= 6'd0;
      end
      case (state_r)
        ST_IDLE: begin
          oe_r  <= 1'b0;
          out_r <= 1'b0;
          if (MDIO_START && (op_s == OP_WRITE)) begin
            state_r <= ST_WRITE;
            frame_r <= T_DATA;
            oe_r    <= 1'b1;
            out_r   <= T_DATA[FRAME_BITS-1];
          end else if (MDIO_START && (op_s == OP_READ)) begin
            state_r <= ST_READ_ADDR;
            frame_r <= T_DATA;
            oe_r    <= 1'b1;
            out_r   <= T_DATA[FRAME_BITS-1];
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          // New bits are presented on MDC falls so they are stable at rises
          if (mdc_fall_s) begin
            if (cnt_r == 6'd63) begin
              state_r <= ST_IDLE;
              oe_r    <= 1'b0;
              out_r   <= 1'b0;
            end else begin
              frame_r <= {frame_r[FRAME_BITS-2:0], frame_r[FRAME_BITS-1]};
              out_r   <= frame_r[FRAME_BITS-2];
            end
          end
        end
        ST_READ_ADDR: begin
          if (mdc_fall_s) begin
            if (cnt_r == 6'd31) begin
              // Turnaround: release the bus, PHY drives from here on
              state_r  <= ST_READ_DATA;
              oe_r     <= 1'b0;
              out_r    <= 1'b0;
              shadow_r <= '0;
            end else begin
              frame_r <= {frame_r[FRAME_BITS-2:0], frame_r[FRAME_BITS-1]};
              out_r   <= frame_r[FRAME_BITS-2];
            end
          end
        end
        ST_READ_DATA: begin
          oe_r  <= 1'b0;
          out_r <= 1'b0;
          // PHY data is sampled on MDC falls, half a period after it rose
          if (mdc_fall_s) begin
            if (cnt_r == 6'd63) begin
              rd_data_r <= {shadow_r, MDIO_IN};
              rdy_r     <= 1'b1;
              state_r   <= ST_IDLE;
            end else begin
              shadow_r <= {shadow_r[DATA_BITS-3:0], MDIO_IN};
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          oe_r    <= 1'b0;
          out_r   <= 1'b0;
        end
      endcase
    end
  end

  assign MDIO_OE  = oe_r;
  assign MDIO_OUT = out_r;
  assign RD_DATA  = rd_data_r;
  assign DATA_RDY = rdy_r;

endmodule

// File: tb/tb_controlador_mdio.sv
// Directed bench for controlador_mdio: writes, reads with a PHY-side data
// model, invalid opcodes, ignored start strobes and a mid-read reset.
module tb_controlador_mdio;

  logic        CLK;
  logic        reset;
  logic        MDIO_START;
  logic [31:0] T_DATA;
  logic        MDIO_IN;
  logic        MDC;
  logic        MDIO_OE;
  logic        MDIO_OUT;
  logic [15:0] RD_DATA;
  logic        DATA_RDY;

  int total = 0;
  int bad   = 0;

  controlador_mdio dut (
    .CLK        (CLK),
    .reset      (reset),
    .MDIO_START (MDIO_START),
    .T_DATA     (T_DATA),
    .MDIO_IN    (MDIO_IN),
    .MDC        (MDC),
    .MDIO_OE    (MDIO_OE),
    .MDIO_OUT   (MDIO_OUT),
    .RD_DATA    (RD_DATA),
    .DATA_RDY   (DATA_RDY)
  );

  // 10 ns system clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issue a write at edge k and check all 64 following edges. With glitch
  // set, extra starts appear at k+10 and k+64 and the start held at k+64
  // carries nxt so it is accepted at k+65 by the next call.
  task automatic run_write(input logic [31:0] f, input bit glitch, input logic [31:0] nxt);
    MDIO_START = 1'b1;
    T_DATA     = f;
    step();
    MDIO_START = 1'b0;
    chk("wr_oe_k", {31'd0, MDIO_OE}, 32'd1);
    chk("wr_out_k", {31'd0, MDIO_OUT}, {31'd0, f[31]});
    chk("wr_mdc_k", {31'd0, MDC}, 32'd0);
    for (int j = 1; j <= 64; j++) begin
      if (glitch && j == 10) begin
        MDIO_START = 1'b1;
        T_DATA     = 32'h6A3C_0000;
      end
      if (glitch && j == 64) begin
        MDIO_START = 1'b1;
        T_DATA     = nxt;
      end
      step();
      if (glitch && j == 10) begin
        MDIO_START = 1'b0;
        T_DATA     = f;
      end
      chk("wr_rdy", {31'd0, DATA_RDY}, 32'd0);
      if (j < 64) begin
        chk("wr_oe", {31'd0, MDIO_OE}, 32'd1);
        chk("wr_mdc", {31'd0, MDC}, 32'(j % 2));
        if (j % 2 == 1) begin
          chk($sformatf("wr_bit%0d", (j - 1) / 2), {31'd0, MDIO_OUT},
              {31'd0, f[31 - (j - 1) / 2]});
        end
      end else begin
        chk("wr_end_mdc", {31'd0, MDC}, 32'd0);
        chk("wr_end_oe", {31'd0, MDIO_OE}, 32'd0);
        chk("wr_end_out", {31'd0, MDIO_OUT}, 32'd0);
      end
    end
  endtask

  // Issue a read at edge k; the PHY model returns w MSB first. prev is the
  // RD_DATA value that must hold until completion. With abort set, reset is
  // raised just before k+40.
  task automatic run_read(input logic [31:0] f, input logic [15:0] w,
                          input logic [15:0] prev, input bit abort);
    MDIO_START = 1'b1;
    T_DATA     = f;
    step();
    MDIO_START = 1'b0;
    chk("rd_oe_k", {31'd0, MDIO_OE}, 32'd1);
    chk("rd_out_k", {31'd0, MDIO_OUT}, {31'd0, f[31]});
    chk("rd_mdc_k", {31'd0, MDC}, 32'd0);
    for (int j = 1; j <= 65; j++) begin
      if (abort && j == 40) begin
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mdc", {31'd0, MDC}, 32'd0);
        chk("rst_oe", {31'd0, MDIO_OE}, 32'd0);
        chk("rst_out", {31'd0, MDIO_OUT}, 32'd0);
        chk("rst_rd", {16'd0, RD_DATA}, 32'd0);
        chk("rst_rdy", {31'd0, DATA_RDY}, 32'd0);
        step();
        chk("rst_rdy_hold", {31'd0, DATA_RDY}, 32'd0);
        reset   = 1'b0;
        MDIO_IN = 1'b0;
        step();
        chk("rst_after_mdc", {31'd0, MDC}, 32'd0);
        chk("rst_after_rdy", {31'd0, DATA_RDY}, 32'd0);
        return;
      end
      if (j >= 34 && j % 2 == 0) begin
        MDIO_IN = w[15 - (j - 34) / 2];
      end
      step();
      if (j <= 31) begin
        chk("rd_addr_oe", {31'd0, MDIO_OE}, 32'd1);
        chk("rd_addr_mdc", {31'd0, MDC}, 32'(j % 2));
        if (j % 2 == 1) begin
          chk($sformatf("rd_addr_bit%0d", (j - 1) / 2), {31'd0, MDIO_OUT},
              {31'd0, f[31 - (j - 1) / 2]});
        end
      end else if (j < 64) begin
        chk("rd_data_oe", {31'd0, MDIO_OE}, 32'd0);
        chk("rd_data_out", {31'd0, MDIO_OUT}, 32'd0);
        chk("rd_data_mdc", {31'd0, MDC}, 32'(j % 2));
        chk("rd_hold", {16'd0, RD_DATA}, {16'd0, prev});
        chk("rd_rdy_low", {31'd0, DATA_RDY}, 32'd0);
      end else if (j == 64) begin
        chk("rd_result", {16'd0, RD_DATA}, {16'd0, w});
        chk("rd_rdy_pulse", {31'd0, DATA_RDY}, 32'd1);
        chk("rd_end_mdc", {31'd0, MDC}, 32'd0);
        chk("rd_end_oe", {31'd0, MDIO_OE}, 32'd0);
      end else begin
        chk("rd_rdy_clear", {31'd0, DATA_RDY}, 32'd0);
        chk("rd_result_hold", {16'd0, RD_DATA}, {16'd0, w});
      end
    end
    MDIO_IN = 1'b0;
  endtask

  // Start with an invalid opcode: nothing may move on the bus
  task automatic run_invalid(input logic [31:0] f, input logic [15:0] prev);
    MDIO_START = 1'b1;
    T_DATA     = f;
    step();
    MDIO_START = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("inv_mdc", {31'd0, MDC}, 32'd0);
      chk("inv_oe", {31'd0, MDIO_OE}, 32'd0);
      chk("inv_out", {31'd0, MDIO_OUT}, 32'd0);
      chk("inv_rdy", {31'd0, DATA_RDY}, 32'd0);
      step();
    end
    chk("inv_rd", {16'd0, RD_DATA}, {16'd0, prev});
  endtask

  initial begin
    reset      = 1'b1;
    MDIO_START = 1'b0;
    T_DATA     = 32'h0;
    MDIO_IN    = 1'b0;
    #12;
    chk("reset_mdc", {31'd0, MDC}, 32'd0);
    chk("reset_oe", {31'd0, MDIO_OE}, 32'd0);
    chk("reset_out", {31'd0, MDIO_OUT}, 32'd0);
    chk("reset_rd", {16'd0, RD_DATA}, 32'd0);
    chk("reset_rdy", {31'd0, DATA_RDY}, 32'd0);
    reset = 1'b0;
    step();
    step();

    // Write with ignored starts at k+10 and k+64, then a start at k+65
    run_write(32'h5A3C_1234, 1'b1, 32'h5000_ABCD);
    run_write(32'h5000_ABCD, 1'b0, 32'h0);
    step();

    // Read returning BEEF
    run_read(32'h6A3C_0000, 16'hBEEF, 16'h0000, 1'b0);
    step();

    // Invalid opcodes leave RD_DATA alone
    run_invalid(32'h4000_0000, 16'hBEEF);
    run_invalid(32'h7000_0000, 16'hBEEF);

    // Read aborted by reset during the data phase, then a clean read
    run_read(32'h6A3C_0000, 16'hA5A5, 16'hBEEF, 1'b1);
    run_read(32'h6A3C_0000, 16'h1234, 16'h0000, 1'b0);

    // Back-to-back reads
    run_read(32'h6842_0000, 16'hFFFF, 16'h1234, 1'b0);
    run_read(32'h6842_0000, 16'h0001, 16'hFFFF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
